// File: rtl/ro_meter_pkg.sv
`default_nettype none
// ============================================================================
// ro_meter_pkg : shared types and constants for the ring-oscillator meter
// Rev 1.0
// ============================================================================
package ro_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_MEAS   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [1:0] c_OFF_CTRL   = 2'd0;
   localparam logic [1:0] c_OFF_GATE   = 2'd1;
   localparam logic [1:0] c_OFF_COUNT  = 2'd2;
   localparam logic [1:0] c_OFF_STATUS = 2'd3;

   localparam int c_CTRL_START  = 0;
   localparam int c_CTRL_CONT   = 1;
   localparam int c_CTRL_IRQ_EN = 2;
   localparam int c_CTRL_ABORT  = 3;
   localparam int c_CTRL_SEL_LO = 4;

   localparam int c_STAT_BUSY = 0;
   localparam int c_STAT_DONE = 1;
   localparam int c_STAT_OVF  = 2;

   localparam int c_GATE_RST = 1000;

   function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  be);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = wdat[8*i +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ro_edge_sync.sv
`default_nettype none
// ============================================================================
// ro_edge_sync : multi-flop synchronizer with a rising-edge pulse output
// Rev 1.0
// ============================================================================
module ro_edge_sync #(
   parameter int SYNC_STG = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise
);

   logic [SYNC_STG-1:0] r_pipe;
   logic                r_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pipe <= '0;
         r_prev <= 1'b0;
      end else begin
         r_pipe <= {r_pipe[SYNC_STG-2:0], i_async};
         r_prev <= r_pipe[SYNC_STG-1];
      end
   end

   assign o_rise = r_pipe[SYNC_STG-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/ro_freq_meter.sv
`default_nettype none
// ============================================================================
// ro_freq_meter : gated edge counter for a muxed ring oscillator, Wishbone slave
// Rev 1.0
// ============================================================================
module ro_freq_meter
   import ro_meter_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          CNT_W      = 32,
   parameter int          GATE_W     = 24,
   parameter int          SETTLE_CYC = 16,
   parameter int          SYNC_STG   = 2
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_dat_i,
   input  logic [31:0] wbs_adr_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        ro_in,
   output logic [3:0]  ro_sel_o,
   output logic        ro_start_o,
   output logic        irq_o
);

   localparam int c_SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   logic w_rise;

   ro_edge_sync #(.SYNC_STG(SYNC_STG)) u_sync (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .i_async (ro_in),
      .o_rise  (w_rise)
   );

   state_t              r_state;
   logic                r_ack;
   logic [31:0]         r_dat;
   logic                r_cont;
   logic                r_irq_en;
   logic [3:0]          r_sel;
   logic [GATE_W-1:0]   r_gate;
   logic                r_ro_start;
   logic [3:0]          r_ro_sel;
   logic [c_SET_W-1:0]  r_settle_cnt;
   logic [GATE_W-1:0]   r_gate_left;
   logic [CNT_W-1:0]    r_edge_cnt;
   logic [CNT_W-1:0]    r_count;
   logic                r_done;
   logic                r_ovf;

   logic                w_hit;
   logic                w_req;
   logic                w_wr;
   logic [1:0]          w_reg;
   logic                w_ctrl_wr;
   logic                w_gate_wr;
   logic                w_stat_wr;
   logic                w_start;
   logic                w_abort;
   logic                w_clr_done;
   logic                w_clr_ovf;
   logic                w_busy;
   logic [3:0]          w_sel_nxt;
   logic [GATE_W-1:0]   w_gate_nxt;
   logic [GATE_W-1:0]   w_gate_load;
   logic [31:0]         w_gate_ext;
   logic [31:0]         w_count_ext;
   logic [31:0]         w_gate_merged;
   logic [31:0]         w_rdata;
   logic                w_unused;

   // A request is only accepted while ack is low, so acks are never back-to-back.
   assign w_hit      = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign w_req      = wbs_stb_i & wbs_cyc_i & w_hit & ~r_ack;
   assign w_wr       = w_req & wbs_we_i;
   assign w_reg      = wbs_adr_i[3:2];
   assign w_ctrl_wr  = w_wr & (w_reg == c_OFF_CTRL) & wbs_sel_i[0];
   assign w_gate_wr  = w_wr & (w_reg == c_OFF_GATE);
   assign w_stat_wr  = w_wr & (w_reg == c_OFF_STATUS) & wbs_sel_i[0];
   assign w_start    = w_ctrl_wr & wbs_dat_i[c_CTRL_START];
   assign w_abort    = w_ctrl_wr & wbs_dat_i[c_CTRL_ABORT];
   assign w_clr_done = w_stat_wr & wbs_dat_i[c_STAT_DONE];
   assign w_clr_ovf  = w_stat_wr & wbs_dat_i[c_STAT_OVF];
   assign w_busy     = (r_state != ST_IDLE);

   always_comb begin
      w_gate_ext              = '0;
      w_gate_ext[GATE_W-1:0]  = r_gate;
      w_count_ext             = '0;
      w_count_ext[CNT_W-1:0]  = r_count;
   end

   assign w_gate_merged = byte_merge(w_gate_ext, wbs_dat_i, wbs_sel_i);
   assign w_gate_nxt    = w_gate_wr ? w_gate_merged[GATE_W-1:0] : r_gate;
   assign w_gate_load   = (w_gate_nxt == '0) ? GATE_W'(1) : w_gate_nxt;
   assign w_sel_nxt     = w_ctrl_wr ? wbs_dat_i[c_CTRL_SEL_LO +: 4] : r_sel;
   assign w_unused      = ^{wbs_adr_i[1:0], w_gate_merged};

   always_comb begin
      w_rdata = '0;
      case (w_reg)
         c_OFF_CTRL:  w_rdata[7:0] = {r_sel, 1'b0, r_irq_en, r_cont, 1'b0};
         c_OFF_GATE:  w_rdata      = w_gate_ext;
         c_OFF_COUNT: w_rdata      = w_count_ext;
         default: begin
            w_rdata[c_STAT_BUSY] = w_busy;
            w_rdata[c_STAT_DONE] = r_done;
            w_rdata[c_STAT_OVF]  = r_ovf;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_cont   <= 1'b0;
         r_irq_en <= 1'b0;
         r_sel    <= '0;
         r_gate   <= GATE_W'(c_GATE_RST);
      end else begin
         r_ack <= w_req;
         r_dat <= (w_req && !wbs_we_i) ? w_rdata : '0;
         if (w_ctrl_wr) begin
            r_cont   <= wbs_dat_i[c_CTRL_CONT];
            r_irq_en <= wbs_dat_i[c_CTRL_IRQ_EN];
         end
         r_sel  <= w_sel_nxt;
         r_gate <= w_gate_nxt;
      end
   end

   // Measurement FSM; later assignments override the W1C clears so a set wins.
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state      <= ST_IDLE;
         r_ro_start   <= 1'b0;
         r_ro_sel     <= '0;
         r_settle_cnt <= '0;
         r_gate_left  <= '0;
         r_edge_cnt   <= '0;
         r_count      <= '0;
         r_done       <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         if (w_clr_done) r_done <= 1'b0;
         if (w_clr_ovf)  r_ovf  <= 1'b0;
         if (w_abort) begin
            r_state    <= ST_IDLE;
            r_ro_start <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_state      <= ST_SETTLE;
                     r_ro_start   <= 1'b1;
                     r_ro_sel     <= w_sel_nxt;
                     r_gate_left  <= w_gate_load;
                     r_settle_cnt <= '0;
                     r_done       <= 1'b0;
                     r_ovf        <= 1'b0;
                  end
               end
               ST_SETTLE: begin
                  r_settle_cnt <= r_settle_cnt + 1'b1;
                  if (r_settle_cnt == c_SET_W'(SETTLE_CYC - 1)) begin
                     r_state    <= ST_MEAS;
                     r_edge_cnt <= '0;
                  end
               end
               ST_MEAS: begin
                  if (w_rise && (r_edge_cnt != '1)) r_edge_cnt <= r_edge_cnt + 1'b1;
                  r_gate_left <= r_gate_left - 1'b1;
                  if (r_gate_left == GATE_W'(1)) r_state <= ST_DONE;
               end
               default: begin
                  r_count <= r_edge_cnt;
                  r_done  <= 1'b1;
                  if (&r_edge_cnt) r_ovf <= 1'b1;
                  if (r_cont) begin
                     r_state      <= ST_SETTLE;
                     r_ro_sel     <= w_sel_nxt;
                     r_gate_left  <= w_gate_load;
                     r_settle_cnt <= '0;
                  end else begin
                     r_state    <= ST_IDLE;
                     r_ro_start <= 1'b0;
                  end
               end
            endcase
         end
      end
   end

   assign wbs_ack_o  = r_ack;
   assign wbs_dat_o  = r_dat;
   assign ro_sel_o   = r_ro_sel;
   assign ro_start_o = r_ro_start;
   assign irq_o      = r_done & r_irq_en;

endmodule
`default_nettype wire
